// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg: shared widths and read-side state encoding for the latch bank
package latch_bank_pkg;
    localparam int IDX_W      = 2;
    localparam int DATA_W     = 8;
    localparam int BANK_DEPTH = 4;
    typedef enum logic [1:0] {IDLE, HOLD, DWELL} state_e;
endpackage

// File: rtl/latch_bank_reader_dwell_timer.sv
// dwell_timer: loadable down-counter that times the gap between scan beats
module dwell_timer #(
    parameter int DWELL_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);
    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DWELL_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // reload on request, otherwise count down and stop at zero
    always_comb cnt_d = load ? LOAD_VAL : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    // counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign zero = cnt_q == '0;
endmodule

// File: rtl/latch_bank_reader.sv
// latch_bank_reader: delivers latch bank bytes over valid/ready, single reads or round-robin scan
module latch_bank_reader
    import latch_bank_pkg::*;
#(
    parameter int DWELL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bank0,
    input  logic [DATA_W-1:0] bank1,
    input  logic [DATA_W-1:0] bank2,
    input  logic [DATA_W-1:0] bank3,
    input  logic              rd_req,
    input  logic [IDX_W-1:0]  rd_sel,
    input  logic              scan_en,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [IDX_W-1:0]  rd_idx,
    output logic              busy
);
    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              single_q, single_d;
    logic              dwell_load, dwell_zero;
    logic [DATA_W-1:0] bank [BANK_DEPTH];

    assign bank[0] = bank0;
    assign bank[1] = bank1;
    assign bank[2] = bank2;
    assign bank[3] = bank3;

    dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
        .clk  (clk),
        .rst_n(rst_n),
        .load (dwell_load),
        .en   (state_q == DWELL),
        .zero (dwell_zero)
    );

    // next-state: capture beats in IDLE/DWELL, hold until transfer, advance scan pointer
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        data_d     = data_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        single_d   = single_q;
        dwell_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d  = HOLD;
                    valid_d  = 1'b1;
                    data_d   = bank[rd_sel];
                    idx_d    = rd_sel;
                    single_d = 1'b1;
                end else if (scan_en) begin
                    state_d  = HOLD;
                    valid_d  = 1'b1;
                    data_d   = bank[ptr_q];
                    idx_d    = ptr_q;
                    single_d = 1'b0;
                end
            end
            HOLD: begin
                if (rd_ready) begin
                    valid_d = 1'b0;
                    if (single_q) begin
                        state_d = IDLE;
                    end else if (scan_en) begin
                        state_d    = DWELL;
                        ptr_d      = ptr_q + 1'b1;
                        dwell_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        ptr_d   = '0;
                    end
                end
            end
            DWELL: begin
                if (!scan_en) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else if (dwell_zero) begin
                    state_d  = HOLD;
                    valid_d  = 1'b1;
                    data_d   = bank[ptr_q];
                    idx_d    = ptr_q;
                    single_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // state, capture register and scan pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            data_q   <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            single_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            single_q <= single_d;
        end
    end

    assign rd_valid = valid_q;
    assign rd_data  = data_q;
    assign rd_idx   = idx_q;
    assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_latch_bank_reader.sv
// tb_latch_bank_reader: directed self-checking bench for latch_bank_reader
module tb_latch_bank_reader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bank0, bank1, bank2, bank3;
    logic       rd_req, scan_en, rd_ready;
    logic [1:0] rd_sel;
    logic       rd_valid, busy;
    logic [7:0] rd_data;
    logic [1:0] rd_idx;
    int         n_checks = 0;
    int         n_errors = 0;

    latch_bank_reader #(.DWELL_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bank0   (bank0),
        .bank1   (bank1),
        .bank2   (bank2),
        .bank3   (bank3),
        .rd_req  (rd_req),
        .rd_sel  (rd_sel),
        .scan_en (scan_en),
        .rd_ready(rd_ready),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .rd_idx  (rd_idx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] scan_exp [5];
        int gap;
        scan_exp[0] = 8'h11; scan_exp[1] = 8'h22; scan_exp[2] = 8'h33;
        scan_exp[3] = 8'h44; scan_exp[4] = 8'h11;
        rst_n = 1'b0; bank0 = 8'h00; bank1 = 8'h00; bank2 = 8'h00; bank3 = 8'h00;
        rd_req = 1'b0; rd_sel = 2'd0; scan_en = 1'b0; rd_ready = 1'b0;
        #2;
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_data", 32'(rd_data), 0);
        check("rst_idx", 32'(rd_idx), 0);
        check("rst_busy", 32'(busy), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        // single read
        bank2 = 8'hA5; rd_sel = 2'd2; rd_req = 1'b1; rd_ready = 1'b1;
        tick();
        rd_req = 1'b0;
        check("single_valid", 32'(rd_valid), 1);
        check("single_data", 32'(rd_data), 32'hA5);
        check("single_idx", 32'(rd_idx), 2);
        check("single_busy", 32'(busy), 1);
        tick();
        check("single_done_valid", 32'(rd_valid), 0);
        check("single_done_busy", 32'(busy), 0);
        // backpressure
        bank1 = 8'h3C; rd_sel = 2'd1; rd_req = 1'b1; rd_ready = 1'b0;
        tick();
        rd_req = 1'b0; bank1 = 8'hFF; rd_sel = 2'd3;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rd_valid), 1);
            check("bp_data", 32'(rd_data), 32'h3C);
            check("bp_idx", 32'(rd_idx), 1);
            tick();
        end
        rd_ready = 1'b1;
        tick();
        check("bp_done_valid", 32'(rd_valid), 0);
        check("bp_done_busy", 32'(busy), 0);
        // scan wrap
        bank0 = 8'h11; bank1 = 8'h22; bank2 = 8'h33; bank3 = 8'h44;
        scan_en = 1'b1;
        tick();
        for (int b = 0; b < 6; b++) begin
            gap = 0;
            while (!rd_valid && gap < 20) begin
                tick();
                gap++;
            end
            check("scan_valid", 32'(rd_valid), 1);
            check("scan_data", 32'(rd_data), (b < 5) ? 32'(scan_exp[b]) : 32'h22);
            check("scan_idx", 32'(rd_idx), 32'(b % 4));
            if (b > 0) check("scan_gap", 32'(gap), 4);
            tick();
        end
        // scan drop during dwell after idx1
        check("drop_in_dwell", 32'(busy), 1);
        scan_en = 1'b0;
        tick();
        check("drop_busy", 32'(busy), 0);
        for (int i = 0; i < 6; i++) begin
            check("drop_no_beat", 32'(rd_valid), 0);
            tick();
        end
        scan_en = 1'b1;
        tick();
        check("restart_valid", 32'(rd_valid), 1);
        check("restart_idx", 32'(rd_idx), 0);
        check("restart_data", 32'(rd_data), 32'h11);
        scan_en = 1'b0;
        tick();
        check("restart_done_busy", 32'(busy), 0);
        // priority: rd_req beats scan_en
        rd_req = 1'b1; rd_sel = 2'd3; scan_en = 1'b1; rd_ready = 1'b0;
        tick();
        check("prio_idx", 32'(rd_idx), 3);
        check("prio_data", 32'(rd_data), 32'h44);
        rd_sel = 2'd0;
        tick();
        check("prio_frozen_idx", 32'(rd_idx), 3);
        rd_req = 1'b0; rd_ready = 1'b1;
        tick();
        check("prio_single_done", 32'(rd_valid), 0);
        tick();
        check("after_single_scan_idx", 32'(rd_idx), 0);
        check("after_single_scan_valid", 32'(rd_valid), 1);
        rd_req = 1'b1; rd_sel = 2'd3;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("ignore_req_dwell", 32'(rd_valid), 0);
            tick();
        end
        check("ignore_dwell_gap", 32'(rd_valid), 0);
        rd_ready = 1'b0;
        tick();
        check("ignore_next_valid", 32'(rd_valid), 1);
        check("ignore_next_idx", 32'(rd_idx), 1);
        check("ignore_next_data", 32'(rd_data), 32'h22);
        // asynchronous reset mid-HOLD
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(rd_valid), 0);
        check("arst_data", 32'(rd_data), 0);
        check("arst_idx", 32'(rd_idx), 0);
        check("arst_busy", 32'(busy), 0);
        rd_req = 1'b0; scan_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_valid", 32'(rd_valid), 0);
        scan_en = 1'b1;
        tick();
        check("post_rst_scan_idx", 32'(rd_idx), 0);
        check("post_rst_scan_data", 32'(rd_data), 32'h11);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
